// File: rtl/duty_gen_pkg.sv
// Shared types and constants for the triangle duty-cycle stimulus generator.
package duty_gen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RISE,
        FALL,
        RET,
        TAIL
    } duty_gen_state_t;

    localparam logic [15:0] DUTY_MID = 16'h8000;
    localparam int unsigned OFF_W    = 17;

endpackage

// File: rtl/duty_cycle_generator_sample_tick_div.sv
// Sample-rate divider: single-cycle tick every SAMPLE_DIV clocks, synchronous clear.
module sample_tick_div #(
    parameter int unsigned SAMPLE_DIV = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(SAMPLE_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CNT_W'(SAMPLE_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/duty_cycle_generator.sv
// Triangle-wave duty-cycle sample source centred on MID, running a programmed number of periods.
// Optional crest marker output enabled by defining DUTY_GEN_CREST_MARK_EN.
module duty_cycle_generator
    import duty_gen_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 50,
    parameter logic [15:0] MID        = DUTY_MID
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [14:0] amplitude,
    input  logic [14:0] step,
    input  logic [7:0]  num_periods,
    output logic [15:0] duty_cycle,
    output logic        duty_cycle_vld,
    output logic        busy,
    output logic        done
`ifdef DUTY_GEN_CREST_MARK_EN
    ,
    output logic        crest_vld
`endif
);

    duty_gen_state_t         state_q, state_d;
    logic signed [OFF_W-1:0] off_q, off_d;
    logic [14:0]             amp_q, amp_d;
    logic [14:0]             stp_q, stp_d;
    logic [7:0]              nper_q, nper_d;
    logic [7:0]              per_q, per_d;
    logic [15:0]             duty_q, duty_d;
    logic                    vld_q, vld_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    fin_q, fin_d;
`ifdef DUTY_GEN_CREST_MARK_EN
    logic                    crest_q, crest_d;
`endif

    logic                    tick;
    logic                    div_clr;
    logic                    accept;
    logic                    emit;
    logic                    per_end;
    logic [7:0]              per_inc;
    logic signed [OFF_W-1:0] amp_s, stp_s, trough;
    logic signed [OFF_W-1:0] up_sum, dn_sum, tr_nxt, fall_nxt;

    // Divider idles at zero so the first sample lands SAMPLE_DIV cycles after accept.
    assign div_clr = (state_q == IDLE);

    sample_tick_div #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_tick_div (
        .clk (clk),
        .rst (rst),
        .clr (div_clr),
        .tick(tick)
    );

    assign accept   = (state_q == IDLE) && start && (|amplitude) && (|step) && (|num_periods);
    assign amp_s    = signed'({2'b00, amp_q});
    assign stp_s    = signed'({2'b00, stp_q});
    assign trough   = -amp_s;
    assign up_sum   = off_q + stp_s;
    assign dn_sum   = off_q - stp_s;
    assign tr_nxt   = trough + stp_s;
    assign fall_nxt = amp_s - stp_s;
    assign per_inc  = per_q + 8'd1;

    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        amp_d   = amp_q;
        stp_d   = stp_q;
        nper_d  = nper_q;
        per_d   = per_q;
        duty_d  = duty_q;
        vld_d   = 1'b0;
        done_d  = 1'b0;
        fin_d   = fin_q;
        emit    = 1'b0;
        per_end = 1'b0;
`ifdef DUTY_GEN_CREST_MARK_EN
        crest_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RISE;
                    off_d   = '0;
                    per_d   = '0;
                    amp_d   = amplitude;
                    stp_d   = (step > amplitude) ? amplitude : step;
                    nper_d  = num_periods;
                    fin_d   = 1'b0;
                end
            end
            RISE: begin
                if (tick) begin
                    emit = 1'b1;
                    if (off_q == amp_s) begin
                        state_d = FALL;
                        off_d   = (fall_nxt < trough) ? trough : fall_nxt;
                    end else begin
                        off_d   = (up_sum > amp_s) ? amp_s : up_sum;
                    end
                end
            end
            FALL: begin
                if (tick) begin
                    emit = 1'b1;
                    if (off_q == trough) begin
                        if (!tr_nxt[OFF_W-1]) begin
                            per_end = 1'b1;
                        end else begin
                            state_d = RET;
                            off_d   = tr_nxt;
                        end
                    end else begin
                        off_d = (dn_sum < trough) ? trough : dn_sum;
                    end
                end
            end
            RET: begin
                if (tick) begin
                    emit = 1'b1;
                    if (!up_sum[OFF_W-1]) begin
                        per_end = 1'b1;
                    end else begin
                        off_d = up_sum;
                    end
                end
            end
            TAIL: begin
                // fin_q marks that the closing sample went out; done follows one cycle later.
                if (fin_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    fin_d   = 1'b0;
                end else if (tick) begin
                    emit  = 1'b1;
                    fin_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (per_end) begin
            off_d   = '0;
            per_d   = per_inc;
            state_d = (per_inc == nper_q) ? TAIL : RISE;
        end

        if (emit) begin
            vld_d  = 1'b1;
            duty_d = MID + off_q[15:0];
`ifdef DUTY_GEN_CREST_MARK_EN
            crest_d = (off_q == amp_s);
`endif
        end

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            off_d   = off_q;
            per_d   = per_q;
            duty_d  = duty_q;
            vld_d   = 1'b0;
            done_d  = 1'b0;
            fin_d   = 1'b0;
`ifdef DUTY_GEN_CREST_MARK_EN
            crest_d = 1'b0;
`endif
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            off_q   <= '0;
            amp_q   <= '0;
            stp_q   <= '0;
            nper_q  <= '0;
            per_q   <= '0;
            duty_q  <= MID;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fin_q   <= 1'b0;
`ifdef DUTY_GEN_CREST_MARK_EN
            crest_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            amp_q   <= amp_d;
            stp_q   <= stp_d;
            nper_q  <= nper_d;
            per_q   <= per_d;
            duty_q  <= duty_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fin_q   <= fin_d;
`ifdef DUTY_GEN_CREST_MARK_EN
            crest_q <= crest_d;
`endif
        end
    end

    assign duty_cycle     = duty_q;
    assign duty_cycle_vld = vld_q;
    assign busy           = busy_q;
    assign done           = done_q;
`ifdef DUTY_GEN_CREST_MARK_EN
    assign crest_vld      = crest_q;
`endif

endmodule

// File: tb/tb_duty_cycle_generator.sv
// Self-checking bench for duty_cycle_generator: directed and random runs against a waveform model.
module tb_duty_cycle_generator;

    localparam int unsigned SD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [14:0] amplitude;
    logic [14:0] step;
    logic [7:0]  num_periods;
    logic [15:0] duty_cycle;
    logic        duty_cycle_vld;
    logic        busy;
    logic        done;
`ifdef DUTY_GEN_CREST_MARK_EN
    logic        crest_vld;
`endif

    int          tests = 0;
    int          fails = 0;
    logic [15:0] cur_duty;
    int          exp_q[$];

    always #5 clk = ~clk;

    duty_cycle_generator #(
        .SAMPLE_DIV(SD),
        .MID       (16'h8000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .amplitude     (amplitude),
        .step          (step),
        .num_periods   (num_periods),
        .duty_cycle    (duty_cycle),
        .duty_cycle_vld(duty_cycle_vld),
        .busy          (busy),
        .done          (done)
`ifdef DUTY_GEN_CREST_MARK_EN
        ,
        .crest_vld     (crest_vld)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waveform as offsets: climb to the crest, descend to the trough, climb back below zero.
    task automatic build_model(input int a, input int s, input int n);
        int se;
        int v;
        se = (s > a) ? a : s;
        exp_q.delete();
        for (int p = 0; p < n; p++) begin
            v = 0;
            while (v < a) begin
                exp_q.push_back(v);
                v = (v + se > a) ? a : v + se;
            end
            exp_q.push_back(a);
            v = a - se;
            while (v > -a) begin
                exp_q.push_back(v);
                v = (v - se < -a) ? -a : v - se;
            end
            exp_q.push_back(-a);
            v = -a + se;
            while (v < 0) begin
                exp_q.push_back(v);
                v = v + se;
            end
        end
        exp_q.push_back(0);
    endtask

    // mode 0: run to completion; 1: abort after k samples; 2: reset after k samples.
    task automatic run(input int a, input int s, input int n, input int inj, input int mode, input int k);
        int v;
        int last;
        int nsamp;
        int bound;
        bit stop;
        bit exp_crest;
        build_model(a, s, n);
        @(negedge clk);
        amplitude   = 15'(a);
        step        = 15'(s);
        num_periods = 8'(n);
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_accept", busy, 1);
        amplitude   = 15'($urandom);
        step        = 15'($urandom);
        num_periods = 8'($urandom_range(1, 255));
        last  = 0;
        nsamp = 0;
        stop  = 1'b0;
        bound = (exp_q.size() + 2) * SD + 8;
        for (int cyc = 1; cyc <= bound && !stop; cyc++) begin
            @(posedge clk);
            #1;
            start     = 1'b0;
            exp_crest = 1'b0;
            if (duty_cycle_vld) begin
                check("vld_spacing", cyc - last, SD);
                check("sample_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    v         = exp_q.pop_front();
                    cur_duty  = 16'(32'h8000 + v);
                    exp_crest = (v == a);
                end
                last = cyc;
                nsamp++;
            end
            check("duty_value", duty_cycle, cur_duty);
`ifdef DUTY_GEN_CREST_MARK_EN
            check("crest_vld", crest_vld, exp_crest);
`endif
            if (done) begin
                check("done_latency", cyc - last, 1);
                check("busy_at_done", busy, 0);
                check("samples_left", exp_q.size(), 0);
                stop = 1'b1;
            end
            if (mode != 0 && nsamp == k) begin
                if (mode == 1) abort = 1'b1;
                else rst = 1'b1;
                stop = 1'b1;
            end
            if (cyc == inj) begin
                start       = 1'b1;
                amplitude   = 15'($urandom_range(1, 32767));
                step        = 15'($urandom_range(1, 32767));
                num_periods = 8'($urandom_range(1, 255));
            end
        end
        if (mode == 0) begin
            check("done_seen", stop, 1);
        end else begin
            @(posedge clk);
            #1;
            abort = 1'b0;
            rst   = 1'b0;
            if (mode == 2) cur_duty = 16'h8000;
            check("stop_busy", busy, 0);
            check("stop_vld", duty_cycle_vld, 0);
            check("stop_done", done, 0);
            check("stop_duty", duty_cycle, cur_duty);
            repeat (3 * SD) begin
                @(posedge clk);
                #1;
                check("idle_vld", duty_cycle_vld, 0);
                check("idle_done", done, 0);
                check("idle_busy", busy, 0);
                check("idle_duty", duty_cycle, cur_duty);
            end
        end
        exp_q.delete();
    endtask

    initial begin
        int ra;
        int rs;
        int rn;
        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        amplitude   = '0;
        step        = '0;
        num_periods = '0;
        cur_duty    = 16'h8000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_duty", duty_cycle, 16'h8000);
        check("rst_vld", duty_cycle_vld, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
`ifdef DUTY_GEN_CREST_MARK_EN
        check("rst_crest", crest_vld, 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        run(4, 2, 1, 0, 0, 0);
        run(100, 100, 2, 0, 0, 0);
        run(5, 3, 1, 0, 0, 0);
        run(5, 20, 1, 0, 0, 0);
        run(32767, 32767, 1, 0, 0, 0);

        // Each zero field must block acceptance.
        for (int z = 0; z < 3; z++) begin
            @(negedge clk);
            amplitude   = (z == 0) ? 15'd0 : 15'd4;
            step        = (z == 1) ? 15'd0 : 15'd2;
            num_periods = (z == 2) ? 8'd0 : 8'd1;
            start       = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (2 * SD) begin
                @(posedge clk);
                #1;
                check("illegal_busy", busy, 0);
                check("illegal_vld", duty_cycle_vld, 0);
            end
        end

        run(4, 2, 2, 9, 0, 0);
        run(4, 2, 1, 0, 1, 3);
        run(4, 2, 1, 0, 2, 5);
        run(4, 2, 1, 0, 0, 0);

        for (int r = 0; r < 6; r++) begin
            ra = $urandom_range(1, 40);
            rs = $urandom_range(1, ra + 8);
            rn = $urandom_range(1, 3);
            run(ra, rs, rn, $urandom_range(0, 30), 0, 0);
        end
        run(1, 1, 3, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
